des_key_sched: RTL
==================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 key_in  input  64  DES key, bit 63 = FIPS bit 1; parity bits ignored.
REQ-005 key_valid  input  1  key_in is presented for loading.
REQ-006 key_ready  output  1  block is idle and accepts a key.
REQ-007 subkey  output  48  current round subkey, PC-2 of key_leftOut/key_rightOut.
REQ-008 subkey_valid  output  1  subkey, round_idx and halves are valid.
REQ-009 subkey_ready  input  1  consumer accepts the current subkey.
REQ-010 round_idx  output  4  DES round of current subkey minus 1 (0 = round 1).
REQ-011 key_leftOut  output  28  C half for the current round, fed to the downstream key pipe register.
REQ-012 key_rightOut  output  28  D half for the current round, fed to the downstream key pipe register.

Function
REQ-013 The FSM SHALL have two states: IDLE (key_ready=1, subkey_valid=0) and GEN (key_ready=0, subkey_valid=1).
REQ-014 A load SHALL occur on a cycle with key_valid=1 and key_ready=1: PC-1 is applied to key_in, C/D are rotated left by 1, the result is registered, round_idx is set to 0, and the FSM enters GEN.
REQ-015 Latency SHALL be one cycle: subkey for round 1 is valid in the cycle after the load.
REQ-016 subkey SHALL be combinational PC-2 of the registered C/D halves, so it is always consistent with key_leftOut/key_rightOut.
REQ-017 A subkey transfer SHALL occur on a cycle with subkey_valid=1 and subkey_ready=1; without a transfer all outputs hold (backpressure).
REQ-018 On a transfer with round_idx<15, C/D SHALL rotate left by the shift of the next round (1 for rounds 1, 2, 9, 16; 2 otherwise), and round_idx increments.
REQ-019 On the transfer with round_idx=15, the FSM SHALL return to IDLE, so key_ready=1 in the next cycle; C/D and round_idx hold their last values.
REQ-020 Rotation SHALL be modulo-28 within each half; C and D never exchange bits.
REQ-021 key_valid while in GEN SHALL be ignored and SHALL NOT disturb generation.
REQ-022 Exactly 16 transfers SHALL follow each load; a load and a transfer can never occur in the same cycle.

Reset
REQ-023 With rst_n=0 at a clock edge, the FSM SHALL enter IDLE, C/D and round_idx SHALL clear to 0, and subkey_valid SHALL be 0. key_ready SHALL be 1 from the following cycle.
REQ-024 Reset asserted during GEN SHALL abort the sequence at that edge; no further subkeys are issued until a new load.

Configuration
REQ-025 Macro DES_KEYSCHED_DECRYPT_EN SHALL add input decrypt (1 bit), sampled only on a load.
REQ-026 With the macro defined and decrypt=1, a load SHALL register the unrotated PC-1 halves (C16=C0), round_idx SHALL start at 15, and each transfer SHALL rotate right by the shift of the round just issued and decrement round_idx. The sequence ends after the transfer at round_idx=0.
REQ-027 With the macro defined and decrypt=0, or with the macro undefined, the block SHALL use encrypt order only; when undefined, the decrypt port SHALL NOT exist.

Verification
REQ-028 Reset, then load key 133457799BBCDFF1 with subkey_ready=1 -> the next cycle gives round_idx=0 and subkey=1B02EFFC7072; 16 consecutive transfers end with round_idx=15 and subkey=CB3D8B0E17F5.
REQ-029 Same key, subkey_ready toggled pseudo-randomly -> identical 16-subkey sequence, outputs stable while stalled, key_ready=1 exactly one cycle after the 16th transfer.
REQ-030 key_valid held high with a second key during GEN -> the sequence for the first key completes unchanged; the second key loads only once in IDLE.
REQ-031 rst_n=0 for one cycle at round_idx=7 -> subkey_valid=0, outputs zero, key_ready=1 afterwards; a fresh load restarts at round 1.
REQ-032 DES_KEYSCHED_DECRYPT_EN defined, decrypt=1, key 133457799BBCDFF1 -> first subkey CB3D8B0E17F5 with round_idx=15, last subkey 1B02EFFC7072 with round_idx=0.

Source files
------------

// File: rtl/des_key_sched_if.sv
// Handshake bundle for des_key_sched: key-load channel plus round-subkey channel.
// The decrypt signal exists only when DES_KEYSCHED_DECRYPT_EN is defined.
interface des_key_sched_if;
  logic [63:0] key_in;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic [27:0] key_leftOut;
  logic [27:0] key_rightOut;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        decrypt;
`endif

  modport master (
`ifdef DES_KEYSCHED_DECRYPT_EN
    output decrypt,
`endif
    output key_in, key_valid, subkey_ready,
    input  key_ready, subkey, subkey_valid, round_idx, key_leftOut, key_rightOut
  );

  modport slave (
`ifdef DES_KEYSCHED_DECRYPT_EN
    input  decrypt,
`endif
    input  key_in, key_valid, subkey_ready,
    output key_ready, subkey, subkey_valid, round_idx, key_leftOut, key_rightOut
  );
endinterface

// File: rtl/des_key_sched.sv
// DES key schedule: PC-1 on load, per-round C/D rotation, combinational PC-2; round 1 valid one cycle
// after load, all outputs hold while subkey_ready is low. DES_KEYSCHED_DECRYPT_EN adds reverse-order decrypt.
module des_key_sched (
  input  logic           clk,
  input  logic           rst_n,
  des_key_sched_if.slave kif
);
  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  // Tables hold FIPS bit numbers; first entry sits in the most significant slot.
  localparam logic [56*7-1:0] PC1_TAB = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [48*6-1:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [6:0]  src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = PC1_TAB[9'((55 - i) * 7) +: 7];
      r[6'(55 - i)] = k[6'(7'd64 - src)];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = PC2_TAB[9'((47 - i) * 6) +: 6];
      r[6'(47 - i)] = cd[6'(7'd56 - {1'b0, src})];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic single_shift(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q, round_nxt;
  logic        dec_q, load_dec;
  logic        load, xfer, last;
  logic        key_ready_c, subkey_valid_c;
  logic [55:0] cd0;

`ifdef DES_KEYSCHED_DECRYPT_EN
  assign load_dec = kif.decrypt;
`else
  assign load_dec = 1'b0;
`endif

  assign cd0       = pc1(kif.key_in);
  assign last      = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);
  assign round_nxt = dec_q ? (round_q - 4'd1) : (round_q + 4'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    xfer           = 1'b0;
    key_ready_c    = 1'b0;
    subkey_valid_c = 1'b0;
    case (state)
      IDLE: begin
        key_ready_c = 1'b1;
        load        = kif.key_valid;
        if (kif.key_valid) state_nxt = GEN;
      end
      GEN: begin
        subkey_valid_c = 1'b1;
        xfer           = kif.subkey_ready;
        if (kif.subkey_ready && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The last transfer leaves C/D and round index untouched so they stay observable in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else if (load) begin
      dec_q <= load_dec;
      if (load_dec) begin
        c_q     <= cd0[55:28];
        d_q     <= cd0[27:0];
        round_q <= 4'd15;
      end else begin
        c_q     <= rotl(cd0[55:28], 1'b0);
        d_q     <= rotl(cd0[27:0], 1'b0);
        round_q <= 4'd0;
      end
    end else if (xfer && !last) begin
      if (dec_q) begin
        c_q <= rotr(c_q, !single_shift(round_q));
        d_q <= rotr(d_q, !single_shift(round_q));
      end else begin
        c_q <= rotl(c_q, !single_shift(round_nxt));
        d_q <= rotl(d_q, !single_shift(round_nxt));
      end
      round_q <= round_nxt;
    end
  end

  assign kif.key_ready    = key_ready_c;
  assign kif.subkey_valid = subkey_valid_c;
  assign kif.subkey       = pc2({c_q, d_q});
  assign kif.round_idx    = round_q;
  assign kif.key_leftOut  = c_q;
  assign kif.key_rightOut = d_q;
endmodule
